contador_timer_param: RTL and testbench
=======================================

# contador_timer_param

Parametrised start-triggered counter and run timer, the successor to the fixed 4-bit counter / 5-bit timer buffer. A rising edge on `start` arms a run. During the run, a configurable-width cycle counter steps up or down with wrap-around, and a run timer measures the run length. The run ends automatically at a programmable timer limit, and the block flags wrap and completion events for downstream control logic.

## Interface
- `CNT_W`, 4: counter width in bits.
- `TMR_W`, 5: timer width in bits.
- `CNT_MAX`, 2**CNT_W-1: counter wrap point; legal range 1..2**CNT_W-1.
- `TMR_LIMIT`, 20: run length in cycles; legal range 1..2**TMR_W-1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: run trigger; only the rising edge (sampled) matters.
- `pause`  in  1: while high in RUN, `count` and `timer` hold.
- `dir`  in  1: 0 = count up, 1 = count down (functional only with `CONTADOR_DIR_EN`).
- `count`  out  CNT_W: counter value.
- `timer`  out  TMR_W: cycles elapsed in the current or last run.
- `running`  out  1: high while state is RUN.
- `wrap`  out  1: one-cycle pulse when `count` wraps.
- `done`  out  1: one-cycle pulse on run completion.

## Operation
- States: IDLE, RUN, DONE.
- `start_d` is a registered copy of `start`; a rising edge is `start & ~start_d`.
- IDLE → RUN on a rising edge: `count` ← 0, `timer` ← 0.
- DONE → RUN on a rising edge: same clear as above (restart).
- RUN, `pause`=0, each edge:
  - `timer` ← `timer`+1.
  - Up: `count` ← `count`+1; at `CNT_MAX`, `count` ← 0 and `wrap` pulses.
  - Down: `count` ← `count`−1; at 0, `count` ← `CNT_MAX` and `wrap` pulses.
- RUN → DONE on the edge where `timer` becomes `TMR_LIMIT`. The `count` step on that edge still happens, and `done` pulses.
- DONE holds `count` and `timer` indefinitely.
- A `start` edge during RUN is ignored; no restart.
- `pause` is ignored outside RUN.
- `pause`=1 on the would-be final edge: no transition; the run completes on the first unpaused edge.

## Timing
- Reset values: `count`=0, `timer`=0, `running`=0, `wrap`=0, `done`=0, state IDLE, `start_d`=0.
- Because reset clears `start_d` to 0, a `start` held high through reset re-arms on the first edge after `reset` drops.
- Start latency: the rising edge is sampled at edge E0, so `running`=1 after E0. After edge Ek, `count`=k mod (`CNT_MAX`+1) when counting up, and `timer`=k.
- `done` and `wrap` are registered, so each is high for exactly the cycle after the edge that caused it.
- `done` and `wrap` may assert together.
- `reset` during RUN: all outputs return to their reset values immediately (asynchronous), and there is no `done` pulse.

## Configuration
- `CONTADOR_DIR_EN` defined: `dir` selects up or down counting per cycle, and may change mid-run.
- `CONTADOR_DIR_EN` undefined: `dir` is ignored and the block counts up only. The port stays present so benches are identical for both builds.

## Structure
- `contador_pkg` holds:
  - `state_t` enum (IDLE, RUN, DONE).
  - Parameter-legality check helper functions.
- Sub-module `edge_rise_det`: registered rising-edge detector with async reset; holds `start_d`.
- Top level holds the FSM and the count/timer datapath.

## Test plan
- Defaults; reset 0, `start` rises at 10 and holds → `running` after first edge; `wrap` after the 16th edge (`count` 15→0); after the 20th edge `timer`=20, `count`=4, `done`=1 for one cycle, then DONE holding 4/20.
- `start` high through a one-cycle `reset` at 80 → outputs 0 during reset; restart on the first edge after release; `done` at the 20th edge after restart.
- `pause` high for 5 cycles mid-run → `count` and `timer` frozen; `done` delayed by exactly 5 cycles.
- `CONTADOR_DIR_EN`, `dir`=1 → `count` sequence 15, 14, …; `wrap` at 0→15; `done` with `count`=12 at `timer`=20.
- `start` toggled during RUN → no restart. `start` re-pulsed in DONE → `count`=0, `timer`=0, new run.
- `CNT_W`=3, `CNT_MAX`=5, `TMR_W`=4, `TMR_LIMIT`=7 → `count` 1..5,0,1; `wrap` after edge 6; `done` at `timer`=7.

Source files
------------

// File: rtl/contador_pkg.sv
// contador_pkg: shared FSM state type and parameter-legality helpers for contador_timer_param
package contador_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic bit cnt_max_ok(input int w, input int m);
    return m >= 1 && m <= (2 ** w) - 1;
  endfunction

  function automatic bit tmr_limit_ok(input int w, input int l);
    return l >= 1 && l <= (2 ** w) - 1;
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// edge_rise_det: registered rising-edge detector with asynchronous active-high reset
//   clk_i, rst_i : clock, async reset (clears the stored copy, so a held-high input re-arms after reset)
//   d_i          : level input
//   rise_o       : d_i & ~previous d_i
module edge_rise_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) d_q <= 1'b0;
    else d_q <= d_i;
  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/contador_timer_param.sv
// contador_timer_param: start-triggered wrap-around counter with run timer and auto-stop at TMR_LIMIT
//   clk, reset (async, active-high), start (rising edge arms a run), pause (holds count/timer in RUN),
//   dir (0 up / 1 down, honoured only when CONTADOR_DIR_EN is defined; otherwise up only),
//   count, timer, running, wrap (1-cycle pulse), done (1-cycle pulse)
module contador_timer_param
  import contador_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int TMR_W     = 5,
  parameter int CNT_MAX   = 2 ** CNT_W - 1,
  parameter int TMR_LIMIT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             dir,
  output logic [CNT_W-1:0] count,
  output logic [TMR_W-1:0] timer,
  output logic             running,
  output logic             wrap,
  output logic             done
);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TMR_LIMIT);

  if (!cnt_max_ok(CNT_W, CNT_MAX)) begin : g_bad_cnt_max
    $error("CNT_MAX out of range 1..2**CNT_W-1");
  end
  if (!tmr_limit_ok(TMR_W, TMR_LIMIT)) begin : g_bad_tmr_limit
    $error("TMR_LIMIT out of range 1..2**TMR_W-1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
  logic             wrap_q, wrap_d, done_q, done_d;
  logic             rise, down, at_end;

  edge_rise_det u_start_edge (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (start),
    .rise_o(rise)
  );

`ifdef CONTADOR_DIR_EN
  assign down = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign down = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_d   = timer_q;
    wrap_d    = 1'b0;
    done_d    = 1'b0;
    timer_inc = timer_q + 1'b1;
    at_end    = down ? (count_q == '0) : (count_q == CNT_TOP);
    if (state_q != RUN) begin
      if (rise) begin
        state_d = RUN;
        count_d = '0;
        timer_d = '0;
      end
    end else if (!pause) begin
      timer_d = timer_inc;
      count_d = at_end ? (down ? CNT_TOP : '0) : (down ? count_q - 1'b1 : count_q + 1'b1);
      wrap_d  = at_end;
      if (timer_inc == TMR_END) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      timer_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end

  assign count   = count_q;
  assign timer   = timer_q;
  assign running = state_q == RUN;
  assign wrap    = wrap_q;
  assign done    = done_q;
endmodule

// File: tb/tb_contador_timer_param.sv
// tb_contador_timer_param: scoreboard bench for the default build plus a CNT_W=3/CNT_MAX=5/TMR_W=4/TMR_LIMIT=7 instance
module tb_contador_timer_param;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, dir = 1'b0, s_start = 1'b0;
  logic [3:0] count;
  logic [4:0] timer;
  logic running, wrap, done;
  logic [2:0] s_count;
  logic [3:0] s_timer;
  logic s_running, s_wrap, s_done;
  logic [11:0] obs, s_obs, e;
  logic [11:0] exp_q[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  contador_timer_param dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .dir(dir),
    .count(count), .timer(timer), .running(running), .wrap(wrap), .done(done)
  );

  contador_timer_param #(.CNT_W(3), .TMR_W(4), .CNT_MAX(5), .TMR_LIMIT(7)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .pause(1'b0), .dir(1'b0),
    .count(s_count), .timer(s_timer), .running(s_running), .wrap(s_wrap), .done(s_done)
  );

  assign obs   = {running, wrap, done, count, timer};
  assign s_obs = {s_running, s_wrap, s_done, 1'b0, s_count, 1'b0, s_timer};

  function automatic logic [11:0] pk(input bit r, input bit w, input bit d, input int c, input int t);
    return {r, w, d, 4'(c), 5'(t)};
  endfunction

  // Default-parameter up run, k edges after the arming edge; st = an unpaused step happened on this edge.
  function automatic logic [11:0] exp_up(input int k, input bit st);
    return pk(k < 20, st && k > 0 && k % 16 == 0, st && k == 20, k % 16, k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) begin
      exp_q.push_back(12'h0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset obs=%h exp=%h", obs, e); end
      checks++;
      if (s_obs !== e) begin errors++; $display("FAIL reset_small obs=%h exp=%h", s_obs, e); end
    end
  endtask

  task automatic test_basic_up();
    reset = 1'b0;
    repeat (2) begin
      exp_q.push_back(12'h0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL idle obs=%h exp=%h", obs, e); end
    end
    start = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      exp_q.push_back(exp_up(k, k > 0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL basic k=%0d obs=%h exp=%h", k, obs, e); end
    end
    repeat (3) begin
      exp_q.push_back(pk(0, 0, 0, 4, 20));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL done_hold obs=%h exp=%h", obs, e); end
    end
  endtask

  task automatic test_reset_in_run();
    start = 1'b0;
    tick();
    start = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      exp_q.push_back(exp_up(k, k > 0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL prereset k=%0d obs=%h exp=%h", k, obs, e); end
    end
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(12'h0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL async_reset obs=%h exp=%h", obs, e); end
    exp_q.push_back(12'h0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_hold obs=%h exp=%h", obs, e); end
    reset = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      exp_q.push_back(exp_up(k, k > 0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rearm k=%0d obs=%h exp=%h", k, obs, e); end
    end
  endtask

  task automatic test_pause();
    int k = 0;
    bit p;
    start = 1'b0;
    tick();
    start = 1'b1;
    for (int c = 0; c <= 26; c++) begin
      p = (c >= 9 && c <= 13) || c == 25;
      pause = p;
      if (c > 0 && !p) k++;
      exp_q.push_back(exp_up(k, c > 0 && !p));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL pause c=%0d obs=%h exp=%h", c, obs, e); end
    end
    pause = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 4, 20));
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL pause_in_done obs=%h exp=%h", obs, e); end
    pause = 1'b0;
  endtask

  task automatic test_start_in_run_and_restart();
    start = 1'b0;
    tick();
    start = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k == 5) start = 1'b0;
      if (k == 8) start = 1'b1;
      exp_q.push_back(exp_up(k, k > 0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL start_in_run k=%0d obs=%h exp=%h", k, obs, e); end
    end
    start = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 4, 20));
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL done_idle obs=%h exp=%h", obs, e); end
    start = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      exp_q.push_back(exp_up(k, k > 0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL restart k=%0d obs=%h exp=%h", k, obs, e); end
    end
  endtask

  task automatic test_dir();
    dir = 1'b1;
    start = 1'b0;
    tick();
    start = 1'b1;
    for (int k = 0; k <= 20; k++) begin
`ifdef CONTADOR_DIR_EN
      exp_q.push_back(pk(k < 20, k % 16 == 1, k == 20, (16 - k % 16) % 16, k));
`else
      exp_q.push_back(exp_up(k, k > 0));
`endif
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL dir k=%0d obs=%h exp=%h", k, obs, e); end
    end
    dir = 1'b0;
  endtask

  task automatic test_small();
    s_start = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      exp_q.push_back(pk(k < 7, k > 0 && k % 6 == 0, k == 7, k % 6, k));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (s_obs !== e) begin errors++; $display("FAIL small k=%0d obs=%h exp=%h", k, s_obs, e); end
    end
    repeat (2) begin
      exp_q.push_back(pk(0, 0, 0, 1, 7));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (s_obs !== e) begin errors++; $display("FAIL small_hold obs=%h exp=%h", s_obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_reset_in_run();
    test_pause();
    test_start_in_run_and_restart();
    test_dir();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
